// File: rtl/spectrum_band_reader.sv
// spectrum_band_reader: reduces FFT bin magnitudes to per-band max levels with decaying peaks and a registered read port
module spectrum_band_reader #(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_BANDS     = 32,
    parameter int BINS_PER_BAND = 8,
    parameter int PEAK_DECAY    = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_mag_valid,
    input  logic [ADDR_WIDTH-1:0]        i_mag_addr,
    input  logic [DATA_WIDTH-1:0]        i_mag_data,
    input  logic                         i_fft_done,
    input  logic [$clog2(NUM_BANDS)-1:0] i_rd_band,
    output logic [DATA_WIDTH-1:0]        o_bar,
    output logic [DATA_WIDTH-1:0]        o_peak,
    output logic                         o_frame_valid,
    output logic                         o_busy,
    output logic                         o_overrun
);
    localparam int BW  = $clog2(NUM_BANDS);
    localparam int BSH = $clog2(BINS_PER_BAND);
    localparam logic [ADDR_WIDTH:0]   L_TOTAL = (ADDR_WIDTH+1)'(NUM_BANDS * BINS_PER_BAND);
    localparam logic [DATA_WIDTH-1:0] L_DECAY = DATA_WIDTH'(PEAK_DECAY);
    localparam logic [BW-1:0]         L_LAST  = BW'(NUM_BANDS - 1);

    typedef enum logic {ACCUM, COMMIT} state_t;

    state_t                r_state, w_next;
    logic [BW-1:0]         r_k;
    logic [DATA_WIDTH-1:0] r_scratch [NUM_BANDS];
    logic [DATA_WIDTH-1:0] r_bar     [NUM_BANDS];
    logic [DATA_WIDTH-1:0] r_peak    [NUM_BANDS];
    logic [DATA_WIDTH-1:0] r_bar_q, r_peak_q;
    logic                  r_frame_valid, r_busy, r_overrun;
    logic                  w_last, w_in_range;
    logic [BW-1:0]         w_band;
    logic [DATA_WIDTH-1:0] w_cur, w_decayed, w_new_peak;

    // Next-state decode plus the band index and commit-side peak arithmetic
    always_comb begin
        w_last     = r_k == L_LAST;
        w_next     = (r_state == ACCUM)
                   ? (i_fft_done ? COMMIT : ACCUM)
                   : (w_last ? ACCUM : COMMIT);
        w_in_range = {1'b0, i_mag_addr} < L_TOTAL;
        w_band     = i_mag_addr[BSH +: BW];
        w_cur      = r_scratch[r_k];
        w_decayed  = (r_peak[r_k] > L_DECAY) ? r_peak[r_k] - L_DECAY : '0;
        w_new_peak = (w_cur > w_decayed) ? w_cur : w_decayed;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ACCUM;
        else
            r_state <= w_next;
    end

    // Accumulate per-band maxima, commit one band per cycle, serve reads every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k           <= '0;
            r_bar_q       <= '0;
            r_peak_q      <= '0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_scratch[b] <= '0;
                r_bar[b]     <= '0;
                r_peak[b]    <= '0;
            end
        end else begin
            r_bar_q       <= r_bar[i_rd_band];
            r_peak_q      <= r_peak[i_rd_band];
            r_frame_valid <= (r_state == COMMIT) && w_last;
            r_busy        <= w_next == COMMIT;
            if (r_state == ACCUM) begin
                r_k <= '0;
                if (i_mag_valid && w_in_range && i_mag_data > r_scratch[w_band])
                    r_scratch[w_band] <= i_mag_data;
            end else begin
                r_k            <= r_k + BW'(1);
                r_bar[r_k]     <= w_cur;
                r_peak[r_k]    <= w_new_peak;
                r_scratch[r_k] <= '0;
                if (i_mag_valid || i_fft_done)
                    r_overrun <= 1'b1;
            end
        end
    end

    assign o_bar         = r_bar_q;
    assign o_peak        = r_peak_q;
    assign o_frame_valid = r_frame_valid;
    assign o_busy        = r_busy;
    assign o_overrun     = r_overrun;
endmodule
